// File: rtl/progloader_pkg.sv
// -----------------------------------------------------------------------------
// progloader_pkg
// Shared definitions for the program loader: loader state encoding, stream
// framing constants and a length validation helper.
// -----------------------------------------------------------------------------
package progloader_pkg;

    // Loader states. IDLE/DONE/ERR are the resting states in which a start
    // pulse is honoured; LEN_HI..CHECK form the busy window.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Stream framing: two length bytes ahead of the data, one checksum after.
    localparam int LEN_BYTES = 2;
    localparam int CHK_BYTES = 1;

    // A word count is loadable when it is non-zero and fits in memory.
    function automatic logic len_ok(input logic [15:0] n, input int nwords);
        return (n != 16'd0) && (int'(n) <= nwords);
    endfunction

endpackage

// File: rtl/progloader_byte_packer.sv
// -----------------------------------------------------------------------------
// progloader_byte_packer
// Assembles a byte stream into WIDTH-bit words, MSB byte first.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_clear         restart word assembly at byte 0 (start of a new load)
//   i_byte_valid    one data byte accepted this cycle
//   i_byte          the accepted data byte
//   o_word_last     combinational: this cycle's byte completes a word
//   o_word_valid    registered word-complete strobe (cycle after o_word_last)
//   o_word          assembled word; stable while o_word_valid is high
// -----------------------------------------------------------------------------
module progloader_byte_packer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte,
    output logic             o_word_last,
    output logic             o_word_valid,
    output logic [WIDTH-1:0] o_word
);

    localparam int BPW = WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic             r_word_valid;
    logic             w_last;

    assign w_last       = i_byte_valid && (r_cnt == CW'(BPW - 1));
    assign o_word_last  = w_last;
    assign o_word_valid = r_word_valid;

    // The accumulator doubles as the output word: after the last byte of a
    // word it holds the complete word, and it only changes again on the next
    // accepted byte, which is no earlier than the edge ending the strobe.
    assign o_word = r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= w_last;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_byte_valid) begin
                r_acc <= (r_acc << 8) | WIDTH'(i_byte);
                if (w_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/progloader.sv
// -----------------------------------------------------------------------------
// progloader
// Loads a length-prefixed, XOR-checksummed byte stream into the CPU's program
// memory write port, starting at address 0, and holds the CPU in reset until
// a complete image has been written and its checksum verified.
//
// Stream: LEN_HI, LEN_LO (word count N), N*BPW data bytes (MSB byte of each
// word first), then one checksum byte = XOR of the data bytes.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start        one-cycle pulse, begins a load from IDLE/DONE/ERR
//   in_valid     byte available on in_data
//   in_data      stream byte
//   in_ready     loader accepts a byte this cycle
//   we, wa, wd   program memory write port (one-cycle write strobe per word)
//   busy         load in progress
//   done         image loaded and checksum matched (held until next start)
//   error        bad length or checksum mismatch (held until next start)
//   cpu_hold     CPU reset hold, low only once an image is verified
//   dbg_state    current loader state for observation
//
// Handshake: a byte transfers on every rising edge where in_valid && in_ready.
// in_ready depends only on the loader state, never on in_valid, so the source
// may hold in_valid high and stream one byte per cycle.
// -----------------------------------------------------------------------------
module progloader
    import progloader_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int NWORDS = 1024,
    localparam int AW     = $clog2(NWORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             we,
    output logic [AW-1:0]    wa,
    output logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_hold,
    output logic [2:0]       dbg_state
);

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_len_hi;
    logic [15:0]   r_len;
    logic [15:0]   r_words;
    logic [7:0]    r_chk;
    logic [AW-1:0] r_wa;

    logic          w_accept;
    logic          w_start_ok;
    logic          w_data_byte;
    logic          w_word_last;
    logic          w_word_valid;
    logic          w_last_word;
    logic [15:0]   w_len;

    // ---------------------------------------------------------------- status
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK: in_ready = 1'b1;
            default:                                 in_ready = 1'b0;
        endcase
    end

    assign busy      = in_ready;
    assign done      = (r_state == ST_DONE);
    assign error     = (r_state == ST_ERR);
    assign cpu_hold  = (r_state != ST_DONE);
    assign dbg_state = r_state;

    assign w_accept    = in_valid && in_ready;
    assign w_start_ok  = start && !busy;
    assign w_data_byte = w_accept && (r_state == ST_DATA);
    assign w_len       = {r_len_hi, in_data};
    // Word-level termination: the byte completing word N-1 ends the data.
    assign w_last_word = w_word_last && ((r_words + 16'd1) == r_len);

    // ------------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) w_state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (w_accept) w_state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (w_accept) w_state_next = len_ok(w_len, NWORDS) ? ST_DATA : ST_ERR;
            end
            ST_DATA: begin
                if (w_last_word) w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_accept) w_state_next = (in_data == r_chk) ? ST_DONE : ST_ERR;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------ load bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len_hi <= '0;
            r_len    <= '0;
            r_words  <= '0;
            r_chk    <= '0;
        end else begin
            if (w_start_ok) begin
                r_words <= '0;
                r_chk   <= '0;
            end
            if (w_accept && (r_state == ST_LEN_HI)) r_len_hi <= in_data;
            if (w_accept && (r_state == ST_LEN_LO)) r_len    <= w_len;
            if (w_data_byte) begin
                r_chk <= r_chk ^ in_data;
                if (w_word_last) r_words <= r_words + 16'd1;
            end
        end
    end

    // Write address advances after each write strobe. The length check bounds
    // the image to NWORDS, so holding at the top address only matters after
    // the final word of a full-depth image and keeps wa from wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wa <= '0;
        end else if (w_start_ok) begin
            r_wa <= '0;
        end else if (w_word_valid && (r_wa != AW'(NWORDS - 1))) begin
            r_wa <= r_wa + AW'(1);
        end
    end

    assign we = w_word_valid;
    assign wa = r_wa;

    // ----------------------------------------------------------- byte packer
    progloader_byte_packer #(
        .WIDTH (WIDTH)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start_ok),
        .i_byte_valid (w_data_byte),
        .i_byte       (in_data),
        .o_word_last  (w_word_last),
        .o_word_valid (w_word_valid),
        .o_word       (wd)
    );

endmodule

// File: tb/tb_progloader.sv
// -----------------------------------------------------------------------------
// tb_progloader
// Randomised and directed bench for progloader. A stream-level reference
// model (byte index within the image, running XOR, expected writes) predicts
// every output each cycle; directed tests pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_progloader;
    import progloader_pkg::*;

    localparam int WIDTH  = 16;
    localparam int NWORDS = 1024;
    localparam int AW     = 10;
    localparam int BPW    = WIDTH / 8;

    // ------------------------------------------------------- clock and reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic             in_ready, we, busy, done, error, cpu_hold;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic [2:0]       dbg_state;

    always #5 clk = ~clk;

    progloader #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_hold  (cpu_hold),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------ bookkeeping
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ------------------------------------------------------- reference model
    // Tracks the load in terms of "how many stream bytes have been consumed".
    logic       m_busy  = 1'b0;
    logic       m_done  = 1'b0;
    logic       m_error = 1'b0;
    logic       m_we    = 1'b0;
    int         m_idx   = 0;
    int         m_n     = 0;
    int         m_words = 0;
    logic [7:0] m_xor   = 8'h00;
    logic [WIDTH-1:0] m_acc = '0;
    logic [AW+WIDTH-1:0] exp_q[$];
    logic [AW+WIDTH-1:0] log_q[$];

    task automatic model_step();
        logic [7:0] b;
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_error = 1'b0; m_we = 1'b0;
            exp_q.delete();
            return;
        end
        m_we = 1'b0;
        if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1; m_done = 1'b0; m_error = 1'b0;
                m_idx = 0; m_xor = 8'h00; m_words = 0;
            end
        end else if (in_valid) begin
            b = in_data;
            if (m_idx == 0) begin
                m_n = int'(b) * 256;
                m_idx = 1;
            end else if (m_idx == 1) begin
                m_n = m_n + int'(b);
                if (m_n == 0 || m_n > NWORDS) begin
                    m_busy = 1'b0; m_error = 1'b1;
                end else begin
                    m_idx = 2;
                end
            end else if (m_idx < 2 + m_n * BPW) begin
                m_xor = m_xor ^ b;
                m_acc = (m_acc << 8) | WIDTH'(b);
                if ((m_idx - 2) % BPW == BPW - 1) begin
                    m_we = 1'b1;
                    exp_q.push_back({AW'(m_words), m_acc});
                    m_words++;
                end
                m_idx++;
            end else begin
                m_busy  = 1'b0;
                m_done  = (b == m_xor);
                m_error = (b != m_xor);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // ------------------------------------------------------ compare process
    initial forever begin
        logic [AW+WIDTH-1:0] e;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(m_busy));
        check("busy",     32'(busy),     32'(m_busy));
        check("done",     32'(done),     32'(m_done));
        check("error",    32'(error),    32'(m_error));
        check("cpu_hold", 32'(cpu_hold), 32'(!m_done));
        check("we",       32'(we),       32'(m_we));
        if (we) begin
            log_q.push_back({wa, wd});
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wa", 32'(wa), 32'(e[AW+WIDTH-1:WIDTH]));
                check("wd", 32'(wd), 32'(e[WIDTH-1:0]));
            end
        end
    end

    // --------------------------------------------------------------- drivers
    logic [7:0] stream_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Start pulse, optionally with a byte presented in the same cycle.
    task automatic pulse_start(input logic with_byte, input logic [7:0] b);
        start = 1'b1; in_valid = with_byte; in_data = b;
        tick();
        start = 1'b0; in_valid = 1'b0;
    endtask

    // gap_mode: 0 = valid held high, 1 = valid every other cycle, 2 = random.
    // start_at: cycle index at which to pulse start mid-stream (-1 = never).
    task automatic send(input int gap_mode, input int start_at);
        int i = 0;
        int cyc = 0;
        logic v, rdy;
        while (i < stream_q.size() && cyc < 5000) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            in_valid = v;
            in_data  = stream_q[i];
            start    = (cyc == start_at);
            rdy      = in_ready;
            tick();
            if (v && rdy) i++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("stream_consumed", 32'(i), 32'(stream_q.size()));
    endtask

    task automatic build(input int n, input logic corrupt);
        logic [7:0] x, b;
        stream_q.delete();
        stream_q.push_back(8'(n >> 8));
        stream_q.push_back(8'(n));
        x = 8'h00;
        for (int k = 0; k < n * BPW; k++) begin
            b = 8'($urandom);
            stream_q.push_back(b);
            x = x ^ b;
        end
        stream_q.push_back(corrupt ? (x ^ 8'h5A) : x);
    endtask

    // ------------------------------------------------------------- watchdog
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------------- tests
    initial begin
        logic corrupt;
        int n;

        // Reset values.
        idle(3);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we",       32'(we),       32'd0);
        check("rst_wa",       32'(wa),       32'd0);
        check("rst_wd",       32'(wd),       32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_state",    32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        idle(2);

        // Nominal load.
        log_q.delete();
        stream_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        pulse_start(1'b0, 8'h00);
        send(0, -1);
        idle(3);
        check("nom_nwrites", 32'(log_q.size()), 32'd2);
        check("nom_w0", 32'(log_q[0]), {6'd0, 10'd0, 16'h1234});
        check("nom_w1", 32'(log_q[1]), {6'd0, 10'd1, 16'hABCD});
        check("nom_done", 32'(done), 32'd1);
        check("nom_cpu_hold", 32'(cpu_hold), 32'd0);

        // Gapped valid; a byte offered together with start must be ignored.
        log_q.delete();
        stream_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        pulse_start(1'b1, 8'h7F);
        send(1, -1);
        idle(3);
        check("gap_nwrites", 32'(log_q.size()), 32'd2);
        check("gap_w1", 32'(log_q[1]), {6'd0, 10'd1, 16'hABCD});
        check("gap_done", 32'(done), 32'd1);

        // Bad checksum.
        log_q.delete();
        stream_q = {8'h00, 8'h01, 8'hFF, 8'h00, 8'h00};
        pulse_start(1'b0, 8'h00);
        send(0, -1);
        idle(3);
        check("bchk_nwrites", 32'(log_q.size()), 32'd1);
        check("bchk_w0", 32'(log_q[0]), {6'd0, 10'd0, 16'hFF00});
        check("bchk_error", 32'(error), 32'd1);
        check("bchk_done", 32'(done), 32'd0);
        check("bchk_cpu_hold", 32'(cpu_hold), 32'd1);

        // Bad lengths: zero and one past the memory depth.
        log_q.delete();
        stream_q = {8'h00, 8'h00};
        pulse_start(1'b0, 8'h00);
        send(0, -1);
        idle(3);
        check("len0_error", 32'(error), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        stream_q = {8'h04, 8'h01};
        pulse_start(1'b0, 8'h00);
        send(0, -1);
        idle(3);
        check("len1025_error", 32'(error), 32'd1);
        check("badlen_nwrites", 32'(log_q.size()), 32'd0);

        // Reset after three data bytes.
        stream_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        pulse_start(1'b0, 8'h00);
        send(0, -1);
        reset = 1'b1;
        #1;
        check("mid_we", 32'(we), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd0);
        check("mid_wa", 32'(wa), 32'd0);
        check("mid_wd", 32'(wd), 32'd0);
        check("mid_cpu_hold", 32'(cpu_hold), 32'd1);
        check("mid_error", 32'(error), 32'd0);
        tick();
        reset = 1'b0;
        idle(2);
        log_q.delete();
        stream_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        pulse_start(1'b0, 8'h00);
        send(0, -1);
        idle(3);
        check("mid_reload_w0", 32'(log_q[0]), {6'd0, 10'd0, 16'h1234});
        check("mid_reload_done", 32'(done), 32'd1);

        // start pulsed during DATA is ignored.
        log_q.delete();
        build(3, 1'b0);
        pulse_start(1'b0, 8'h00);
        send(0, 4);
        idle(3);
        check("ign_nwrites", 32'(log_q.size()), 32'd3);
        check("ign_done", 32'(done), 32'd1);

        // Restart from DONE with a full-depth image.
        log_q.delete();
        build(NWORDS, 1'b0);
        pulse_start(1'b0, 8'h00);
        check("restart_done_clr", 32'(done), 32'd0);
        send(0, -1);
        idle(3);
        check("full_nwrites", 32'(log_q.size()), 32'(NWORDS));
        check("full_first_wa", 32'(log_q[0][AW+WIDTH-1:WIDTH]), 32'd0);
        check("full_last_wa", 32'(log_q[NWORDS-1][AW+WIDTH-1:WIDTH]), 32'(NWORDS - 1));
        check("full_done", 32'(done), 32'd1);

        // Randomised images, gaps, corruption and mid-load start pulses.
        for (int t = 0; t < 24; t++) begin
            n = $urandom_range(1, 8);
            corrupt = ($urandom_range(0, 3) == 0);
            build(n, corrupt);
            log_q.delete();
            pulse_start($urandom_range(0, 1) == 1, 8'($urandom));
            send($urandom_range(0, 2), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : -1);
            idle(2);
            check("rnd_nwrites", 32'(log_q.size()), 32'(n));
            check("rnd_done", 32'(done), 32'(!corrupt));
            check("rnd_error", 32'(error), 32'(corrupt));
        end

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/progloader.md
# progloader

Program loader for the CPU's writable program memory. Accepts a byte stream over a valid/ready handshake, assembles bytes into WIDTH-bit instruction words, and writes them sequentially from address 0 into the program memory's write port. Holds the CPU in reset until a complete, checksum-verified image has been written.

## Interface

Parameters:
- WIDTH, 16, instruction word width; must be a multiple of 8 (BPW = WIDTH/8 bytes per word)
- NWORDS, 1024, program memory depth in words; AW = $clog2(NWORDS)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- we  out  1  program memory write enable, one-cycle pulse per word
- wa  out  AW  write address
- wd  out  WIDTH  write data
- busy  out  1  load in progress
- done  out  1  sticky; image loaded and checksum matched
- error  out  1  sticky; bad length or checksum mismatch
- cpu_hold  out  1  holds the CPU in reset while high

## Operation

- Stream format: LEN_HI, LEN_LO (16-bit word count N, MSB first), then N×BPW data bytes (each word MSB byte first), then one checksum byte.
- Checksum is the XOR of all data bytes only; the length bytes are excluded.
- A byte is accepted on any cycle where in_valid && in_ready.
- States:
  - IDLE: no bytes accepted.
  - LEN_HI, LEN_LO: accept the two length bytes.
  - DATA: accept data bytes.
  - CHECK: accept the checksum byte.
  - DONE, ERR: terminal until the next start.
- Transitions:
  - start in IDLE/DONE/ERR → LEN_HI; clears done, error, the word counter and the checksum; sets cpu_hold.
  - start while busy is ignored.
  - LEN_LO accepted → if N == 0 or N > NWORDS then ERR, else DATA.
  - DATA: after the BPW-th byte of a word, write the word. After word N−1, go to CHECK.
  - CHECK accepted → byte == running XOR ? DONE : ERR.
- Addressing: wa starts at 0 and increments by one per written word. It never wraps, because N ≤ NWORDS is enforced.
- A checksum failure leaves the words already written in memory; error = 1 and cpu_hold stays 1.
- cpu_hold is 0 only in DONE.

## Timing

- in_ready is combinational from state: 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 otherwise. It never depends on in_valid.
- Write latency: the final byte of a word is accepted in cycle t; we = 1 in cycle t+1, with wa/wd registered and stable for that cycle.
- Back-to-back bytes are accepted at one per cycle with no bubbles; writes can therefore occur every BPW cycles.
- done/error rise in the cycle after the checksum byte is accepted. An ERR caused by a bad length rises in the cycle after LEN_LO is accepted.
- busy = 1 in LEN_HI..CHECK.
- Reset values: state IDLE, in_ready 0, we 0, wa 0, wd 0, busy 0, done 0, error 0, cpu_hold 1.
- Reset mid-load aborts immediately; no further writes; the CPU stays held.
- start in the same cycle as a valid byte while in IDLE: the byte is not accepted (in_ready = 0 that cycle).

## Structure

- Shared package:
  - state enumeration (IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR)
  - LEN_BYTES = 2
  - CHK_BYTES = 1
- A single module is natural. The optional sub-module is byte_packer, which handles byte count within a word, shift-in to WIDTH and the word-complete strobe.
- The loader's write port drives a program memory variant with a synchronous write port and an unchanged combinational read.

## Test plan

- Nominal load: start, then bytes 00 02 12 34 AB CD 40 with in_valid held high → we at wa=0 with wd=0x1234, then at wa=1 with wd=0xABCD; done=1; cpu_hold=0.
- Gapped valid: the same image with in_valid toggling every other cycle → identical writes; in_ready stays 1 throughout.
- Bad checksum: 00 01 FF 00 00 → one write of 0xFF00 at wa=0; error=1, done=0, cpu_hold=1.
- Bad length: 00 00 → ERR with no writes. Separately, 04 01 (1025 > 1024) → ERR with no writes.
- Reset mid-load: assert reset after 3 data bytes → all outputs take their reset values. A subsequent start and a full image loads from wa=0.
- Restart and ignore: start pulsed during DATA has no effect. start pulsed from DONE clears done and a new load proceeds; full depth N=1024 writes wa=0..1023 and never wraps.
